// File: rtl/mem_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared types and constants for the CPU-side memory bus
//               controller. These are the access state encoding, the default
//               bus widths and the memory RW encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;

    // Memory RW pin encoding
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl_if
// Description : Bundles the control-unit request side and the asynchronous
//               memory handshake side of the bus controller. The slave
//               modport is the controller's view. The master modport is the
//               view of the control unit plus the memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_ctrl_if
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    // Control-unit side
    logic              req;
    logic              rw;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              err;
    // Memory side
    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_mfc;

    modport slave (
        input  req, rw, addr_in, wdata_in, mem_dout, mem_mfc,
        output busy, done, rdata, err, mem_en, mem_rw, mem_addr, mem_din
    );

    modport master (
        output req, rw, addr_in, wdata_in, mem_dout, mem_mfc,
        input  busy, done, rdata, err, mem_en, mem_rw, mem_addr, mem_din
    );

endinterface
`default_nettype wire

// File: rtl/mem_bus_ctrl_mfc_sync.sv
`default_nettype none
// ============================================================================
// Module      : mfc_sync
// Description : STAGES-deep flop chain that brings the asynchronous memory
//               MFC into the clk domain. It resets to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mfc_sync #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_async,
    output logic      o_sync
);

    logic [STAGES-1:0] r_chain;

    // Shift the raw MFC through the chain; the last flop is the safe copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl
// Description : CPU-side memory bus controller. It accepts one read or write
//               at a time, latches address/data (MAR/MDR) and runs the
//               EN/MFC four-phase handshake through an MFC synchroniser. It
//               returns read data with a one-cycle done pulse.
//               Optional macro MEM_TIMEOUT_EN adds a per-phase MFC timeout
//               (TIMEOUT_CYC) that ends the access with err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = 2
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    mem_bus_ctrl_if.slave bus
);

    state_t            r_state;
    state_t            w_next;
    logic              w_mfc_s;
    logic              w_accept;
    logic              w_capture;
    logic              w_busy;
    logic              w_done;
    logic              w_en;
    logic              w_timeout;

    logic              r_mem_rw;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic [DATA_W-1:0] r_rdata;

    mfc_sync #(
        .STAGES (SYNC_STAGES)
    ) u_mfc_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (bus.mem_mfc),
        .o_sync  (w_mfc_s)
    );

    // State register; reset returns to IDLE at once so EN drops mid-access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs of the handshake sequencer
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_en      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req) begin
                    w_accept = 1'b1;
                    w_next   = SETUP;
                end
            end
            SETUP: begin
                // Bus is already driven; a stale MFC must clear before EN rises
                w_busy = 1'b1;
                if (!w_mfc_s) begin
                    w_next = STROBE;
                end
            end
            STROBE: begin
                w_busy = 1'b1;
                w_en   = 1'b1;
                if (w_mfc_s) begin
                    w_capture = (r_mem_rw == RW_READ);
                    w_next    = RELEASE;
                end else if (w_timeout) begin
                    w_next = DONE;
                end
            end
            RELEASE: begin
                w_busy = 1'b1;
                if (!w_mfc_s) begin
                    w_next = DONE;
                end else if (w_timeout) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // MAR/MDR latch on acceptance; read data captured on MFC in STROBE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_rw   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_accept) begin
                r_mem_rw   <= bus.rw;
                r_mem_addr <= bus.addr_in;
                r_mem_din  <= bus.wdata_in;
            end
            if (w_capture) begin
                r_rdata <= bus.mem_dout;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int C_CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [C_CNT_W-1:0] r_cnt;
    logic               r_err;

    // Cycles spent in the current wait phase; cleared on every phase entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state == STROBE || r_state == RELEASE) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Fires on the last allowed cycle of a phase
    assign w_timeout = (r_cnt == C_CNT_W'(TIMEOUT_CYC - 1));

    // Remember whether the move into DONE was caused by an expired wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout &&
                     (((r_state == STROBE)  && !w_mfc_s) ||
                      ((r_state == RELEASE) &&  w_mfc_s));
        end
    end

    assign bus.err = r_err && (r_state == DONE);
`else
    assign w_timeout = 1'b0;
    assign bus.err   = 1'b0;
`endif

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.rdata    = r_rdata;
    assign bus.mem_en   = w_en;
    assign bus.mem_rw   = r_mem_rw;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_ctrl
// Description : Scoreboard bench for mem_bus_ctrl. The bench models an
//               asynchronous handshake memory with random response delays
//               and keeps a reference memory image for expected read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctrl;
    import mem_bus_pkg::*;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int SYNC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bus_ctrl #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .SYNC_STAGES (SYNC)
`ifdef MEM_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (8)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          dones  = 0;
    int          issued = 0;
    int          en_cycles = 0;
    int          last_done_cyc = 0;
    bit          expect_b2b = 0;
    logic [15:0] last_rd = 16'h0;

    logic [15:0] dev_mem [0:65535];
    logic [15:0] ref_mem [0:65535];
    bit          ideal = 0;
    bit          mute  = 0;
    bit          stuck_mfc = 0;
    logic        m_mfc = 1'b0;

    assign bus.mem_mfc = m_mfc | stuck_mfc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Asynchronous memory: respond to EN after a random delay, drop MFC after EN falls
    initial begin
        int dly;
        bus.mem_dout = 16'h0;
        forever begin
            @(posedge bus.mem_en);
            dly = ideal ? 0 : int'($urandom_range(1, 35));
            if (dly != 0) #(dly);
            if (!mute && bus.mem_en) begin
                if (bus.mem_rw == RW_READ) bus.mem_dout = dev_mem[bus.mem_addr];
                else                       dev_mem[bus.mem_addr] = bus.mem_din;
                m_mfc = 1'b1;
            end
            if (bus.mem_en) @(negedge bus.mem_en);
            dly = ideal ? 0 : int'($urandom_range(1, 35));
            if (dly != 0) #(dly);
            m_mfc = 1'b0;
            bus.mem_dout = 16'($urandom);
        end
    end

    // Monitor: pops the scoreboard on every done and checks the held bus
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_en) begin
                en_cycles++;
                chk("en_implies_busy", bus.busy, 1);
            end
            if (bus.busy) begin
                chk("busy_has_request", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    chk("mem_addr_hold", bus.mem_addr, sb[0].addr);
                    chk("mem_rw_hold", bus.mem_rw, sb[0].rd);
                    chk("mem_din_hold", bus.mem_din, sb[0].wd);
                end
            end
            if (bus.done) begin
                dones++;
                last_done_cyc = cyc;
                chk("done_expected", sb.size() != 0, 1);
                chk("busy_low_in_done", bus.busy, 0);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rdata", bus.rdata, e.exp_rdata);
                    chk("err", bus.err, e.exp_err);
                    if (e.chk_lat) chk("latency", cyc - e.acc_cyc, 3 + 2 * SYNC);
                    if (e.exp_err) chk("strobe_cycles_before_timeout", en_cycles, 8);
                end
                en_cycles = 0;
            end else if (!bus.busy) begin
                chk("err_outside_done", bus.err, 0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.busy == 1'b0 && bus.done == 1'b0) && n < 1000);
        if (n >= 1000) begin
            checks++;
            fails++;
            $display("FAIL idle_timeout: controller still busy after %0d cycles", n);
        end
    endtask

    // mode 0: drop req after acceptance, 1: hold req, 2: scramble inputs while busy
    task automatic access(input logic rd, input logic [15:0] a, input logic [15:0] d,
                          input int mode, input bit lat, input bit to);
        exp_t e;
        wait_idle();
        bus.req = 1'b1; bus.rw = rd; bus.addr_in = a; bus.wdata_in = d;
        e.rd = rd; e.addr = a; e.wd = d; e.acc_cyc = cyc + 1; e.chk_lat = lat; e.exp_err = to;
        if (to) begin
            e.exp_rdata = last_rd;
        end else if (rd == RW_READ) begin
            e.exp_rdata = ref_mem[a];
            last_rd     = ref_mem[a];
        end else begin
            ref_mem[a]  = d;
            e.exp_rdata = last_rd;
        end
        sb.push_back(e);
        issued++;
        if (expect_b2b) chk("b2b_accept_gap", e.acc_cyc - last_done_cyc, 2);
        @(negedge clk);
        chk("busy_after_accept", bus.busy, 1);
        if (mode == 0) begin
            bus.req = 1'b0;
        end else if (mode == 2) begin
            int n = 0;
            while (bus.busy && n < 500) begin
                bus.req = 1'($urandom); bus.rw = 1'($urandom);
                bus.addr_in = 16'($urandom); bus.wdata_in = 16'($urandom);
                @(negedge clk);
                n++;
            end
            bus.req = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            dev_mem[i] = 16'h0;
            ref_mem[i] = 16'h0;
        end
        dev_mem[0] = 16'h700C; ref_mem[0] = 16'h700C;
        dev_mem[1] = 16'hB000; ref_mem[1] = 16'hB000;
        dev_mem[2] = 16'h6080; ref_mem[2] = 16'h6080;
        for (int i = 16'h20; i < 16'h30; i++) begin
            dev_mem[i] = 16'($urandom);
            ref_mem[i] = dev_mem[i];
        end
        bus.req = 1'b0; bus.rw = 1'b0; bus.addr_in = 16'h0; bus.wdata_in = 16'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_mem_en", bus.mem_en, 0);
        chk("reset_rdata", bus.rdata, 0);
        chk("reset_mem_addr", bus.mem_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Program read with an ideal memory: exact latency
        ideal = 1;
        access(RW_READ, 16'h0000, 16'h0, 0, 1, 0);
        wait_idle();
        ideal = 0;

        // Write then read back
        access(RW_WRITE, 16'h0020, 16'h1234, 0, 0, 0);
        access(RW_READ, 16'h0020, 16'h0, 0, 0, 0);

        // Back-to-back reads with req held
        access(RW_READ, 16'h0001, 16'h0, 1, 0, 0);
        expect_b2b = 1;
        access(RW_READ, 16'h0002, 16'h0, 0, 0, 0);
        expect_b2b = 0;

        // Scrambled inputs while busy
        access(RW_WRITE, 16'h0021, 16'hBEEF, 2, 0, 0);
        access(RW_READ, 16'h0021, 16'h0, 2, 0, 0);

        // Reset in STROBE with MFC high
        access(RW_READ, 16'h0001, 16'h0, 0, 0, 0);
        begin
            int n = 0;
            while (!(bus.mem_en && bus.mem_mfc) && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("reached_strobe_with_mfc", bus.mem_en && bus.mem_mfc, 1);
        end
        stuck_mfc = 1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_rw", bus.mem_rw, 0);
        issued -= sb.size();
        sb.delete();
        last_rd = 16'h0;
        en_cycles = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        access(RW_READ, 16'h0002, 16'h0, 0, 0, 0);
        repeat (8) begin
            @(negedge clk);
            chk("en_held_for_stale_mfc", bus.mem_en, 0);
        end
        stuck_mfc = 0;
        wait_idle();

`ifdef MEM_TIMEOUT_EN
        // Memory never answers: STROBE times out
        mute = 1;
        access(RW_READ, 16'h0001, 16'h0, 0, 0, 1);
        wait_idle();
        mute = 0;
        access(RW_READ, 16'h0001, 16'h0, 0, 0, 0);
`endif

        // Randomised traffic
        for (int k = 0; k < 40; k++) begin
            logic        r;
            logic [15:0] a;
            r = 1'($urandom);
            a = 16'h0020 + 16'($urandom_range(0, 15));
            access(r, a, 16'($urandom), ($urandom_range(0, 1) == 0) ? 0 : 2, 0, 0);
        end

        wait_idle();
        repeat (10) @(negedge clk);
        chk("done_count", dones, issued);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
